// File: rtl/led_scanout_if.sv
// Panel-side pins of the LED scan-out engine, grouped so the driver and the
// panel model share one bundle.
interface led_scanout_if;
    logic [3:0] row_addr;
    logic       sdata;
    logic       sclk;
    logic       latch;
    logic       oe_n;
    logic       frame_start;

    modport master (
        output row_addr,
        output sdata,
        output sclk,
        output latch,
        output oe_n,
        output frame_start
    );

    modport slave (
        input row_addr,
        input sdata,
        input sclk,
        input latch,
        input oe_n,
        input frame_start
    );
endinterface

// File: rtl/led_scanout.sv
// 16x16 LED panel scan-out: snapshots the occupancy matrix once per frame and
// shifts it out row by row with shift clock, latch, row address and output enable.
module led_scanout #(
    parameter int CLK_DIV      = 2,
    parameter int BLANK_CYCLES = 4,
    parameter int ON_CYCLES    = 256
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [255:0]   matrix,
    led_scanout_if.master  panel
);

    localparam int BIT_CYCLES = 2 * CLK_DIV;
    localparam int MAX_AB     = (BIT_CYCLES > BLANK_CYCLES) ? BIT_CYCLES : BLANK_CYCLES;
    localparam int CNT_MAX    = (MAX_AB > ON_CYCLES) ? MAX_AB : ON_CYCLES;
    localparam int CW         = $clog2(CNT_MAX + 1);

    localparam logic [CW-1:0] BIT_LAST   = CW'(BIT_CYCLES - 1);
    localparam logic [CW-1:0] SCLK_HI    = CW'(CLK_DIV);
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
    localparam logic [CW-1:0] ON_LAST    = CW'(ON_CYCLES - 1);

    typedef enum logic [2:0] {
        S_LOAD,
        S_SHIFT,
        S_BLANK,
        S_LATCH,
        S_DISPLAY
    } state_t;

    // state names the phase whose outputs are presented after the next edge,
    // so every output is a register that already holds that phase's value.
    state_t         state;
    logic [3:0]     row;
    logic [3:0]     bit_idx;
    logic [CW-1:0]  cnt;
    logic [255:0]   snapshot;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state             <= S_LOAD;
            row               <= 4'd0;
            bit_idx           <= 4'd0;
            cnt               <= '0;
            snapshot          <= '0;
            panel.row_addr    <= 4'd0;
            panel.sdata       <= 1'b0;
            panel.sclk        <= 1'b0;
            panel.latch       <= 1'b0;
            panel.oe_n        <= 1'b1;
            panel.frame_start <= 1'b0;
        end else begin
            panel.frame_start <= 1'b0;
            panel.latch       <= 1'b0;
            case (state)
                S_LOAD: begin
                    snapshot          <= matrix;
                    row               <= 4'd0;
                    bit_idx           <= 4'd15;
                    cnt               <= '0;
                    panel.frame_start <= 1'b1;
                    panel.oe_n        <= 1'b1;
                    panel.sclk        <= 1'b0;
                    panel.sdata       <= 1'b0;
                    state             <= S_SHIFT;
                end
                S_SHIFT: begin
                    panel.oe_n  <= 1'b1;
                    panel.sdata <= snapshot[{row, bit_idx}];
                    panel.sclk  <= (cnt >= SCLK_HI);
                    if (cnt == BIT_LAST) begin
                        cnt     <= '0;
                        bit_idx <= bit_idx - 4'd1;
                        if (bit_idx == 4'd0)
                            state <= S_BLANK;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_BLANK: begin
                    // Row address only moves here, while the panel is dark.
                    panel.oe_n     <= 1'b1;
                    panel.sclk     <= 1'b0;
                    panel.sdata    <= 1'b0;
                    panel.row_addr <= row;
                    if (cnt == BLANK_LAST) begin
                        cnt   <= '0;
                        state <= S_LATCH;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_LATCH: begin
                    panel.latch <= 1'b1;
                    panel.oe_n  <= 1'b1;
                    cnt         <= '0;
                    state       <= S_DISPLAY;
                end
                S_DISPLAY: begin
                    panel.oe_n <= 1'b0;
                    if (cnt == ON_LAST) begin
                        cnt <= '0;
                        if (row == 4'd15) begin
                            state <= S_LOAD;
                        end else begin
                            row     <= row + 4'd1;
                            bit_idx <= 4'd15;
                            state   <= S_SHIFT;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= S_LOAD;
            endcase
        end
    end

endmodule

// File: tb/tb_led_scanout.sv
// Directed bench for led_scanout: default-timing instance plus a fast-timing
// instance (CLK_DIV=1, BLANK_CYCLES=1, ON_CYCLES=8) sharing clock and reset.
module tb_led_scanout;

    localparam int ROW_P   = 325;
    localparam int FRAME_P = 5201;

    logic         clk;
    logic         reset;
    logic [255:0] matrix;

    led_scanout_if pif ();
    led_scanout_if pif2 ();

    led_scanout dut (
        .clk    (clk),
        .reset  (reset),
        .matrix (matrix),
        .panel  (pif)
    );

    led_scanout #(.CLK_DIV(1), .BLANK_CYCLES(1), .ON_CYCLES(8)) dut2 (
        .clk    (clk),
        .reset  (reset),
        .matrix (matrix),
        .panel  (pif2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors    = 0;
    int miscompares = 0;

    int          rel;
    int          cyc_abs = 0;
    logic [15:0] cap   [16];
    logic [3:0]  rowad [16];
    int          ones_n, latch_n, fs_n, viol_n;
    logic        prev_sclk;
    logic [3:0]  prev_row;
    int          last2 = -1;
    int          gap2  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_acc();
        for (int i = 0; i < 16; i++) begin
            cap[i]   = '0;
            rowad[i] = 4'hx;
        end
        ones_n    = 0;
        latch_n   = 0;
        fs_n      = 0;
        viol_n    = 0;
        prev_sclk = pif.sclk;
        prev_row  = pif.row_addr;
    endtask

    // One clock; samples both DUTs 1 time unit after the edge.
    task automatic tick();
        int r, p;
        @(posedge clk);
        #1;
        rel++;
        cyc_abs++;
        if (rel >= 1 && rel < FRAME_P) begin
            r = (rel - 1) / ROW_P;
            p = (rel - 1) % ROW_P;
            if (pif.sclk && !prev_sclk)
                cap[r] = {cap[r][14:0], pif.sdata};
            if (p == 100)
                rowad[r] = pif.row_addr;
        end
        ones_n  += int'(pif.sdata);
        latch_n += int'(pif.latch);
        fs_n    += int'(pif.frame_start);
        if (pif.row_addr != prev_row && !pif.oe_n)
            viol_n++;
        prev_sclk = pif.sclk;
        prev_row  = pif.row_addr;
        if (pif2.frame_start) begin
            if (last2 >= 0)
                gap2 = cyc_abs - last2;
            last2 = cyc_abs;
        end
    endtask

    task automatic run_to(input int stop_rel);
        while (rel < stop_rel)
            tick();
    endtask

    initial begin
        reset  = 1'b0;
        matrix = 256'h1;
        rel    = -100;
        repeat (5) tick();

        chk("rst_row_addr", 32'(pif.row_addr), 32'd0);
        chk("rst_sdata", 32'(pif.sdata), 32'd0);
        chk("rst_sclk", 32'(pif.sclk), 32'd0);
        chk("rst_latch", 32'(pif.latch), 32'd0);
        chk("rst_oe_n", 32'(pif.oe_n), 32'd1);
        chk("rst_frame_start", 32'(pif.frame_start), 32'd0);
        chk("rst2_oe_n", 32'(pif2.oe_n), 32'd1);

        // Frame A: only pixel (0,0) lit.
        reset = 1'b1;
        tick();
        chk("load_frame_start", 32'(pif.frame_start), 32'd1);
        chk("load_oe_n", 32'(pif.oe_n), 32'd1);
        rel = 0;
        clear_acc();
        run_to(1);
        chk("c1_frame_start", 32'(pif.frame_start), 32'd0);
        chk("c1_sclk2", 32'(pif2.sclk), 32'd0);
        run_to(2);
        chk("c2_sclk", 32'(pif.sclk), 32'd0);
        chk("c2_sclk2", 32'(pif2.sclk), 32'd1);
        run_to(3);
        chk("c3_sclk", 32'(pif.sclk), 32'd1);
        chk("c3_sclk2", 32'(pif2.sclk), 32'd0);
        run_to(34);
        chk("c34_latch2", 32'(pif2.latch), 32'd1);
        run_to(60);
        chk("c60_sdata", 32'(pif.sdata), 32'd0);
        run_to(61);
        chk("c61_sdata", 32'(pif.sdata), 32'd1);
        chk("c61_sclk", 32'(pif.sclk), 32'd0);
        run_to(64);
        chk("c64_sdata", 32'(pif.sdata), 32'd1);
        chk("c64_sclk", 32'(pif.sclk), 32'd1);
        run_to(65);
        chk("c65_sdata", 32'(pif.sdata), 32'd0);
        chk("c65_oe_n", 32'(pif.oe_n), 32'd1);
        run_to(68);
        chk("c68_latch", 32'(pif.latch), 32'd0);
        run_to(69);
        chk("c69_latch", 32'(pif.latch), 32'd1);
        chk("c69_oe_n", 32'(pif.oe_n), 32'd1);
        run_to(70);
        chk("c70_oe_n", 32'(pif.oe_n), 32'd0);
        chk("c70_latch", 32'(pif.latch), 32'd0);
        run_to(325);
        chk("c325_oe_n", 32'(pif.oe_n), 32'd0);
        run_to(326);
        chk("c326_oe_n", 32'(pif.oe_n), 32'd1);
        run_to(389);
        chk("c389_row_addr", 32'(pif.row_addr), 32'd0);
        run_to(390);
        chk("c390_row_addr", 32'(pif.row_addr), 32'd1);
        run_to(394);
        chk("c394_latch", 32'(pif.latch), 32'd1);
        run_to(4944);
        chk("c4944_latch", 32'(pif.latch), 32'd1);
        run_to(FRAME_P - 1);
        chk("A_frame_start_count", 32'(fs_n), 32'd0);
        chk("A_sdata_ones", 32'(ones_n), 32'd4);
        chk("A_latch_count", 32'(latch_n), 32'd16);
        chk("A_row_addr_lit_change", 32'(viol_n), 32'd0);
        chk("A_row0_bits", 32'(cap[0]), 32'h0001);
        chk("A_row5_bits", 32'(cap[5]), 32'h0000);
        chk("A_row15_bits", 32'(cap[15]), 32'h0000);
        matrix = {16{16'hF00F}};
        tick();
        chk("A_next_frame_start", 32'(pif.frame_start), 32'd1);

        // Frame B: x0-3 and x12-15 lit on every row.
        rel = 0;
        clear_acc();
        run_to(FRAME_P - 1);
        for (int r = 0; r < 16; r++) begin
            chk($sformatf("B_row%0d_bits", r), 32'(cap[r]), 32'hF00F);
            chk($sformatf("B_row%0d_addr", r), 32'(rowad[r]), 32'(r));
        end
        chk("B_row_addr_lit_change", 32'(viol_n), 32'd0);
        chk("fast_frame_period", 32'(gap2), 32'd673);
        matrix = '1;
        tick();
        chk("B_next_frame_start", 32'(pif.frame_start), 32'd1);

        // Frame C: matrix cleared mid-frame must not tear the snapshot.
        rel = 0;
        clear_acc();
        run_to(1000);
        matrix = '0;
        run_to(FRAME_P - 1);
        for (int r = 0; r < 16; r++)
            chk($sformatf("C_row%0d_bits", r), 32'(cap[r]), 32'hFFFF);
        tick();
        chk("C_next_frame_start", 32'(pif.frame_start), 32'd1);

        // Frame D: picks up the cleared matrix.
        rel = 0;
        clear_acc();
        run_to(FRAME_P - 1);
        chk("D_sdata_ones", 32'(ones_n), 32'd0);
        chk("D_row3_bits", 32'(cap[3]), 32'h0000);
        chk("D_row15_bits", 32'(cap[15]), 32'h0000);
        matrix = 256'h1;
        tick();
        chk("D_next_frame_start", 32'(pif.frame_start), 32'd1);

        // Frame E: reset dropped during row 7 display.
        rel = 0;
        clear_acc();
        run_to(2400);
        chk("E_row7_oe_n", 32'(pif.oe_n), 32'd0);
        chk("E_row7_addr", 32'(pif.row_addr), 32'd7);
        reset = 1'b0;
        tick();
        chk("E_rst_oe_n", 32'(pif.oe_n), 32'd1);
        chk("E_rst_row_addr", 32'(pif.row_addr), 32'd0);
        chk("E_rst_latch", 32'(pif.latch), 32'd0);
        chk("E_rst_frame_start", 32'(pif.frame_start), 32'd0);
        reset = 1'b1;
        tick();
        chk("E_restart_frame_start", 32'(pif.frame_start), 32'd1);
        rel = 0;
        clear_acc();
        run_to(400);
        chk("E_restart_row0_bits", 32'(cap[0]), 32'h0001);
        chk("E_restart_row0_addr", 32'(rowad[0]), 32'd0);
        chk("E_restart_row1_addr", 32'(pif.row_addr), 32'd1);
        chk("E_restart_frame_start_count", 32'(fs_n), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
